imm_stream: RTL

- Streaming, parametrised image-mask accelerator.
- Sits between the pixel source and the frame writer. Takes one pixel per beat on a valid/ready input stream and emits one pixel per beat on a valid/ready output stream.
- Combines each pixel inside a placeable mask window with an on-chip, writable mask memory, using one of four run-time modes.
- Mask read latency is fully pipelined, and the whole pipeline stalls cleanly under backpressure.

---
 rtl/imm_stream.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/imm_stream.sv
// Streaming image-mask combiner: three-stage valid/ready pipeline that merges pixels
// inside a placeable window with an on-chip writable mask memory.
`timescale 1ns/1ps
module imm_stream #(
    parameter int unsigned PIX_W     = 12,
    parameter int unsigned ROW_W     = 9,
    parameter int unsigned COL_W     = 8,
    parameter int unsigned MASK_ROWS = 64,
    parameter int unsigned MASK_COLS = 128,
    parameter int unsigned KEY_COLOR = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [PIX_W-1:0]             s_pixel,
    input  logic [ROW_W-1:0]             s_row,
    input  logic [COL_W-1:0]             s_col,
    input  logic                         s_sof,
    input  logic [ROW_W-1:0]             cfg_row_off,
    input  logic [COL_W-1:0]             cfg_col_off,
    input  logic [1:0]                   cfg_mode,
    input  logic                         mw_en,
    input  logic [$clog2(MASK_ROWS)-1:0] mw_row,
    input  logic [$clog2(MASK_COLS)-1:0] mw_col,
    input  logic [PIX_W-1:0]             mw_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [PIX_W-1:0]             m_pixel,
    output logic [ROW_W-1:0]             m_row,
    output logic [COL_W-1:0]             m_col,
    output logic                         m_sof,
    output logic                         m_hit
);

    localparam int unsigned MR_W   = $clog2(MASK_ROWS);
    localparam int unsigned MC_W   = $clog2(MASK_COLS);
    localparam int unsigned AW     = MR_W + MC_W;
    localparam int unsigned DEPTH  = MASK_ROWS * MASK_COLS;
    localparam int unsigned ROW_EW = ROW_W + 1;
    localparam int unsigned COL_EW = COL_W + 1;

    logic en;
    logic accept;

    assign en      = ~m_valid | m_ready;
    assign s_ready = en & rst_n;
    assign accept  = s_valid & s_ready;

    // Active config, replaced by the cfg_* inputs on an accepted start-of-frame beat
    logic [ROW_W-1:0] act_row_off;
    logic [COL_W-1:0] act_col_off;
    logic [1:0]       act_mode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_row_off <= '0;
            act_col_off <= '0;
            act_mode    <= '0;
        end else if (accept && s_sof) begin
            act_row_off <= cfg_row_off;
            act_col_off <= cfg_col_off;
            act_mode    <= cfg_mode;
        end
    end

    // The sof beat itself must already see the new config
    logic [ROW_W-1:0]  eff_row_off;
    logic [COL_W-1:0]  eff_col_off;
    logic [1:0]        eff_mode;
    logic [ROW_EW-1:0] row_e, row_lo, row_hi;
    logic [COL_EW-1:0] col_e, col_lo, col_hi;
    logic              hit_c;
    logic [AW-1:0]     addr_c;

    assign eff_row_off = s_sof ? cfg_row_off : act_row_off;
    assign eff_col_off = s_sof ? cfg_col_off : act_col_off;
    assign eff_mode    = s_sof ? cfg_mode    : act_mode;

    assign row_e  = ROW_EW'(s_row);
    assign row_lo = ROW_EW'(eff_row_off);
    assign row_hi = row_lo + ROW_EW'(MASK_ROWS);
    assign col_e  = COL_EW'(s_col);
    assign col_lo = COL_EW'(eff_col_off);
    assign col_hi = col_lo + COL_EW'(MASK_COLS);

    assign hit_c  = (row_e >= row_lo) && (row_e < row_hi) &&
                    (col_e >= col_lo) && (col_e < col_hi);
    assign addr_c = {MR_W'(s_row - eff_row_off), MC_W'(s_col - eff_col_off)};

    // Stage 1: window test and mask address
    logic             s1_valid, s1_sof, s1_hit;
    logic [PIX_W-1:0] s1_pixel;
    logic [ROW_W-1:0] s1_row;
    logic [COL_W-1:0] s1_col;
    logic [1:0]       s1_mode;
    logic [AW-1:0]    s1_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_hit   <= 1'b0;
            s1_pixel <= '0;
            s1_row   <= '0;
            s1_col   <= '0;
            s1_mode  <= '0;
            s1_addr  <= '0;
        end else if (en) begin
            s1_valid <= s_valid;
            s1_sof   <= s_sof;
            s1_hit   <= hit_c;
            s1_pixel <= s_pixel;
            s1_row   <= s_row;
            s1_col   <= s_col;
            s1_mode  <= eff_mode;
            s1_addr  <= addr_c;
        end
    end

    // Mask memory: read-first, read held during stalls, contents survive reset
    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] rd_data;

    always_ff @(posedge clk) begin
        if (mw_en) begin
            mem[{mw_row, mw_col}] <= mw_data;
        end
        if (en) begin
            rd_data <= mem[s1_addr];
        end
    end

    // Stage 2: carries beat alongside the memory read
    logic             s2_valid, s2_sof, s2_hit;
    logic [PIX_W-1:0] s2_pixel;
    logic [ROW_W-1:0] s2_row;
    logic [COL_W-1:0] s2_col;
    logic [1:0]       s2_mode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_hit   <= 1'b0;
            s2_pixel <= '0;
            s2_row   <= '0;
            s2_col   <= '0;
            s2_mode  <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_hit   <= s1_hit;
            s2_pixel <= s1_pixel;
            s2_row   <= s1_row;
            s2_col   <= s1_col;
            s2_mode  <= s1_mode;
        end
    end

    logic [PIX_W-1:0] res_c;

    always_comb begin
        res_c = s2_pixel;
        if (s2_hit) begin
            case (s2_mode)
                2'd0:    res_c = s2_pixel ^ rd_data;
                2'd1:    res_c = s2_pixel & rd_data;
                2'd2:    res_c = s2_pixel | rd_data;
                default: res_c = (rd_data != PIX_W'(KEY_COLOR)) ? rd_data : s2_pixel;
            endcase
        end
    end

    // Stage 3: registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_pixel <= '0;
            m_row   <= '0;
            m_col   <= '0;
            m_sof   <= 1'b0;
            m_hit   <= 1'b0;
        end else if (en) begin
            m_valid <= s2_valid;
            m_pixel <= res_c;
            m_row   <= s2_row;
            m_col   <= s2_col;
            m_sof   <= s2_sof;
            m_hit   <= s2_hit;
        end
    end

endmodule
